// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types for the message scheduler and compression datapath.
package sha256_pkg;

    localparam int SHA_ROUNDS = 64;
    localparam int SHA_WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SHA_WORD_W-1:0] K_ROM [SHA_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: sel=0 gives sigma0, sel=1 gives sigma1 (not the round-function Sigma).
module sha256_small_sigma
    import sha256_pkg::*;
(
    input  logic                  sel,
    input  logic [SHA_WORD_W-1:0] x,
    output logic [SHA_WORD_W-1:0] y
);

    logic [SHA_WORD_W-1:0] sigma0;
    logic [SHA_WORD_W-1:0] sigma1;

    assign sigma0 = {x[6:0],  x[31:7]}  ^ {x[17:0], x[31:18]} ^ (x >> 3);
    assign sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    assign y      = sel ? sigma1 : sigma0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Streams W0..W63 and K0..K63 for one padded block using a 16-word sliding window.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA_ROUNDS,
    parameter int WORD_W = SHA_WORD_W
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [16*WORD_W-1:0] message_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic [WORD_W-1:0]    Wt_o,
    output logic [WORD_W-1:0]    Kt_o,
    output logic [5:0]           t_o,
    output logic                 last_o,
    output logic                 v_o,
    input  logic                 yumi_i
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t            state_reg, state_next;
    logic [5:0]        t_reg, t_next;
    logic [WORD_W-1:0] window_reg [16];
    logic [WORD_W-1:0] shift_in   [16];
    logic [WORD_W-1:0] msg_word   [16];
    logic [WORD_W-1:0] s0, s1, w_new;
    logic              load, advance;

    sha256_small_sigma u_sigma0 (.sel(1'b0), .x(window_reg[1]),  .y(s0));
    sha256_small_sigma u_sigma1 (.sel(1'b1), .x(window_reg[14]), .y(s1));

    // W[t+16] from W[t..t+15]; registered into the window tail, never combinational to Wt_o.
    assign w_new = s1 + window_reg[9] + s0 + window_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_window
            assign msg_word[gi] = message_i[(16-gi)*WORD_W-1 -: WORD_W];
            if (gi == 15) begin : g_tail
                assign shift_in[gi] = w_new;
            end else begin : g_body
                assign shift_in[gi] = window_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        load       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (v_i) begin
                    load       = 1'b1;
                    t_next     = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (yumi_i) begin
                    advance = 1'b1;
                    t_next  = t_reg + 6'd1;
                    if (t_reg == LAST_T) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 16; i++) begin
                window_reg[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                window_reg[i] <= msg_word[i];
            end
        end else if (advance) begin
            for (int i = 0; i < 16; i++) begin
                window_reg[i] <= shift_in[i];
            end
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign v_o     = (state_reg == RUN);
    assign Wt_o    = window_reg[0];
    assign Kt_o    = K_ROM[t_reg];
    assign t_o     = t_reg;
    assign last_o  = v_o && (t_reg == LAST_T);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed plus randomized checks of the SHA-256 message scheduler against a behavioural model.
module tb_sha256_msg_schedule;

    logic         clk_i;
    logic         reset_n_i;
    logic [511:0] message_i;
    logic         v_i;
    logic         ready_o;
    logic [31:0]  Wt_o;
    logic [31:0]  Kt_o;
    logic [5:0]   t_o;
    logic         last_o;
    logic         v_o;
    logic         yumi_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_w [64];
    logic [31:0] obs_w [64];

    localparam logic [31:0] KREF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .message_i (message_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .Wt_o      (Wt_o),
        .Kt_o      (Kt_o),
        .t_o       (t_o),
        .last_o    (last_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook full-array expansion of the schedule.
    task automatic build_ref(input logic [511:0] m);
        for (int t = 0; t < 16; t++) begin
            ref_w[t] = m[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) begin
            m[32*i +: 32] = $urandom;
        end
        return m;
    endfunction

    // Called on a falling edge. Offers msg, then consumes words with the requested yumi pattern.
    task automatic run_block(input string name, input logic [511:0] msg,
                             input int stall_at, input int stall_len, input bit rnd_yumi,
                             input bit spam_vi, input bit chain, input logic [511:0] next_msg,
                             input int abort_at, input bit expect_immediate);
        int n;
        int t;
        int stalls;
        int guard;
        build_ref(msg);
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (expect_immediate) check({name, "_b2b_wait"}, n, 0);
        check({name, "_accept_ready"}, {31'd0, ready_o}, 32'd1);
        message_i = msg;
        v_i       = 1'b1;
        yumi_i    = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        if (spam_vi) message_i = rand_block();
        else         v_i = 1'b0;
        t = 0;
        stalls = 0;
        guard = 0;
        while (t < 64) begin
            if (t == abort_at) begin
                #2 reset_n_i = 1'b0;
                #1;
                check({name, "_rst_v"},     {31'd0, v_o},     32'd0);
                check({name, "_rst_ready"}, {31'd0, ready_o}, 32'd1);
                check({name, "_rst_last"},  {31'd0, last_o},  32'd0);
                @(negedge clk_i);
                reset_n_i = 1'b1;
                v_i       = 1'b0;
                yumi_i    = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk_i);
                    check({name, "_post_rst_v"},     {31'd0, v_o},     32'd0);
                    check({name, "_post_rst_t"},     {26'd0, t_o},     32'd0);
                    check({name, "_post_rst_ready"}, {31'd0, ready_o}, 32'd1);
                end
                yumi_i = 1'b0;
                $display("block %s: reset at t=%0d, no further words", name, abort_at);
                return;
            end
            check({name, "_v"},     {31'd0, v_o},     32'd1);
            check({name, "_ready"}, {31'd0, ready_o}, 32'd0);
            check({name, "_t"},     {26'd0, t_o},     t);
            check({name, "_Wt"},    Wt_o,             ref_w[t]);
            check({name, "_Kt"},    Kt_o,             KREF[t]);
            check({name, "_last"},  {31'd0, last_o},  (t == 63) ? 32'd1 : 32'd0);
            obs_w[t] = Wt_o;
            if (t == stall_at && stalls < stall_len) begin
                yumi_i = 1'b0;
                stalls++;
            end else if (rnd_yumi) begin
                yumi_i = ($urandom_range(0, 2) != 0);
            end else begin
                yumi_i = 1'b1;
            end
            if (t == 63) begin
                message_i = chain ? next_msg : message_i;
                v_i       = chain;
            end
            @(posedge clk_i);
            if (yumi_i) t++;
            @(negedge clk_i);
            guard++;
            if (guard > 1000) begin
                check({name, "_word_timeout"}, guard, 0);
                yumi_i = 1'b0;
                return;
            end
        end
        yumi_i = 1'b0;
        check({name, "_end_ready"}, {31'd0, ready_o}, 32'd1);
        check({name, "_end_v"},     {31'd0, v_o},     32'd0);
        $display("block %s: 64 words in %0d cycles, W0=%08h W63=%08h", name, guard, obs_w[0], obs_w[63]);
    endtask

    logic [511:0] abc_blk;
    logic [511:0] ff_blk;
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        ff_blk  = '1;
        reset_n_i = 1'b0;
        message_i = '0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;

        repeat (2) @(negedge clk_i);
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_v",     {31'd0, v_o},     32'd0);
        check("reset_last",  {31'd0, last_o},  32'd0);
        check("reset_t",     {26'd0, t_o},     32'd0);
        check("reset_Wt",    Wt_o,             32'd0);
        check("reset_Kt",    Kt_o,             32'h428a2f98);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // "abc" with yumi held high
        run_block("abc", abc_blk, -1, 0, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0);
        check("abc_W0",  obs_w[0],  32'h61626380);
        check("abc_W15", obs_w[15], 32'h00000018);
        check("abc_W16", obs_w[16], 32'h61626380);
        check("abc_W17", obs_w[17], 32'h000F0000);

        // backpressure: five idle cycles at t=16
        @(negedge clk_i);
        run_block("abc_stall", abc_blk, 16, 5, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0);
        check("stall_W17", obs_w[17], 32'h000F0000);

        // v_i with another block during RUN must be ignored
        run_block("spam", rand_block(), -1, 0, 1'b1, 1'b1, 1'b0, '0, -1, 1'b0);
        @(negedge clk_i);
        check("spam_still_idle", {31'd0, ready_o}, 32'd1);

        // back-to-back: second block offered while the first finishes
        blk_a = rand_block();
        blk_b = rand_block();
        run_block("b2b_a", blk_a, -1, 0, 1'b0, 1'b0, 1'b1, blk_b, -1, 1'b0);
        run_block("b2b_b", blk_b, -1, 0, 1'b1, 1'b0, 1'b0, '0, -1, 1'b1);
        check("b2b_b_W0", obs_w[0], blk_b[511:480]);

        // wrap-around arithmetic
        run_block("all_ff", ff_blk, -1, 0, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0);
        check("all_ff_W16", obs_w[16], 32'h203FFFFC);

        // random blocks with random backpressure
        for (int b = 0; b < 3; b++) begin
            run_block($sformatf("rand%0d", b), rand_block(), -1, 0, 1'b1, 1'b0, 1'b0, '0, -1, 1'b0);
        end

        // asynchronous reset mid-block at t=20
        run_block("abort", rand_block(), -1, 0, 1'b0, 1'b0, 1'b0, '0, 20, 1'b0);

        // scheduler still healthy after reset
        run_block("after_rst", abc_blk, -1, 0, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
